// File: rtl/commutation_sequencer.sv
// ---------------------------------------------------------------------------
// commutation_sequencer
//
// Purpose: hands switching vectors from the MPC controller to the matrix
// converter's decoder/four_step datapath. Each accepted vector change is
// followed by one full four-step commutation and a minimum dwell before the
// next change is accepted. A clamp (fault) request forces CLAMP and is held
// until cleared. Also generates the step tick and the control interrupt.
//
// Optional feature: define SEQ_INTERRUPT_EN to build the interrupt counter.
// Without it, interrupt is tied low and int_limit is ignored.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req_valid/ready   vector request handshake (ready is combinational)
//   req_v, req_dir    requested vector index / per-phase current direction
//   clamp_signal      clamp/fault request (level)
//   clamp_clr         clear latched clamp (only honoured in CLAMP)
//   int_limit         interrupt half-period in ticks
//   v, dir            applied vector / direction
//   tick              one-clk step strobe every TICK_DIV clks
//   busy, clamped     state flags (registered)
//   vec_count         commutations started, wraps
//   interrupt         control-loop interrupt square wave
//
// States:
//   state   | meaning
//   IDLE    | waiting for a request, req_ready may be high
//   COMMUTE | four-step commutation in progress, timer counts ticks
//   DWELL   | holding the vector for the minimum dwell
//   CLAMP   | fault latched, v/dir frozen until clamp_clr
// ---------------------------------------------------------------------------
module commutation_sequencer #(
    parameter int TICK_DIV   = 200,
    parameter int STEP_TICKS = 1,
    parameter int MIN_DWELL  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_v,
    input  logic [2:0]  req_dir,
    input  logic        clamp_signal,
    input  logic        clamp_clr,
    input  logic [15:0] int_limit,
    output logic [4:0]  v,
    output logic [2:0]  dir,
    output logic        tick,
    output logic        busy,
    output logic        clamped,
    output logic [15:0] vec_count,
    output logic        interrupt
);

    localparam int TDW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TDW-1:0] TDIV_LAST = TDW'(TICK_DIV - 1);
    localparam logic [15:0] COMMUTE_TICKS = 16'(4 * STEP_TICKS);
    localparam logic [15:0] DWELL_TICKS   = 16'(MIN_DWELL);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMMUTE = 2'd1,
        S_DWELL   = 2'd2,
        S_CLAMP   = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [TDW-1:0] tdiv, tdiv_nxt;
    logic [15:0]    timer, timer_nxt;
    logic [4:0]     v_nxt;
    logic [2:0]     dir_nxt;
    logic [15:0]    count_nxt;

    // Tick divider: free-running; tick is registered so it lines up with
    // tdiv == TICK_DIV-1 without a combinational decode on the output.
    assign tdiv_nxt = (tdiv == TDIV_LAST) ? '0 : tdiv + TDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            tdiv <= '0;
            tick <= 1'b0;
        end else begin
            tdiv <= tdiv_nxt;
            tick <= (tdiv_nxt == TDIV_LAST);
        end
    end

    assign req_ready = (state == S_IDLE) && !clamp_signal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            v         <= '0;
            dir       <= '0;
            timer     <= '0;
            vec_count <= '0;
            busy      <= 1'b0;
            clamped   <= 1'b0;
        end else begin
            state     <= state_nxt;
            v         <= v_nxt;
            dir       <= dir_nxt;
            timer     <= timer_nxt;
            vec_count <= count_nxt;
            busy      <= (state_nxt != S_IDLE);
            clamped   <= (state_nxt == S_CLAMP);
        end
    end

    always_comb begin
        state_nxt = state;
        v_nxt     = v;
        dir_nxt   = dir;
        timer_nxt = timer;
        count_nxt = vec_count;
        if (clamp_signal) begin
            // Clamp wins over everything, including a same-cycle request.
            state_nxt = S_CLAMP;
        end else begin
            case (state)
                S_IDLE: begin
                    // An identical request is acknowledged but starts nothing.
                    if (req_valid && ({req_v, req_dir} != {v, dir})) begin
                        v_nxt     = req_v;
                        dir_nxt   = req_dir;
                        timer_nxt = COMMUTE_TICKS;
                        count_nxt = vec_count + 16'd1;
                        state_nxt = S_COMMUTE;
                    end
                end
                S_COMMUTE: begin
                    if (tick) begin
                        timer_nxt = timer - 16'd1;
                        if (timer == 16'd1) begin
                            if (MIN_DWELL == 0) begin
                                state_nxt = S_IDLE;
                            end else begin
                                timer_nxt = DWELL_TICKS;
                                state_nxt = S_DWELL;
                            end
                        end
                    end
                end
                S_DWELL: begin
                    if (tick) begin
                        timer_nxt = timer - 16'd1;
                        if (timer == 16'd1) begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
                S_CLAMP: begin
                    if (clamp_clr) begin
                        v_nxt     = '0;
                        timer_nxt = '0;
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

`ifdef SEQ_INTERRUPT_EN
    logic [15:0] icnt;
    logic [16:0] icnt_inc;

    // One extra bit so icnt+1 cannot wrap before the compare.
    assign icnt_inc = {1'b0, icnt} + 17'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            icnt      <= '0;
            interrupt <= 1'b0;
        end else if (tick) begin
            if (icnt_inc >= {1'b0, int_limit}) begin
                icnt      <= '0;
                interrupt <= ~interrupt;
            end else begin
                icnt <= icnt_inc[15:0];
            end
        end
    end
`else
    logic unused_int_limit;
    assign unused_int_limit = ^int_limit;
    assign interrupt        = 1'b0;
`endif

endmodule
